// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq
//   Sequential multi-precision adder. An operand pair of WORDS x 16 bits is
//   accepted over a valid/ready handshake, then added one 16-bit word per
//   cycle (least-significant first) through a single cla_16_bit, with the
//   carry chained through a register. The wide sum, carry-out and signed
//   overflow are offered over a second valid/ready handshake.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake (a, b, cin)
//     out_valid / out_ready result handshake (sum, cout, overflow)
//
//   States:
//     IDLE | ready for a new operand pair (in_ready=1)
//     RUN  | adding word r_k of the latched operands
//     DONE | result held until out_ready (out_valid=1)

module cla_16_bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout,
  output logic        P,
  output logic        G
);
  logic [15:0] w_p, w_g;
  logic [3:0]  w_gp, w_gg;
  logic [4:0]  w_cg;

  function automatic logic [3:0] grp_sum(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    logic [3:0] s;
    logic       cc;
    cc = c;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | ((x[i] ^ y[i]) & cc);
    end
    return s;
  endfunction

  assign w_p = A ^ B;
  assign w_g = A & B;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign w_gp[j] = &w_p[4*j +: 4];
    assign w_gg[j] = w_g[4*j+3]
                   | (w_p[4*j+3] & w_g[4*j+2])
                   | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                   | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
    assign S[4*j +: 4] = grp_sum(A[4*j +: 4], B[4*j +: 4], w_cg[j]);
  end

  // Group carries fully expanded so no carry depends on another carry net.
  assign w_cg[0] = Cin;
  assign w_cg[1] = w_gg[0] | (w_gp[0] & Cin);
  assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Cin);
  assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & Cin);
  assign G       = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
  assign P       = &w_gp;
  assign w_cg[4] = G | (P & Cin);
  assign Cout    = w_cg[4];
endmodule

module multiword_adder_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                overflow
);
  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic [KW-1:0] r_k;
  logic          r_carry, r_cout, r_ovf, r_in_ready, r_out_valid;

  logic [15:0]   w_a_word, w_b_word, w_s;
  logic          w_cout, w_cla_p_unused, w_cla_g_unused;

  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_k == KW'(i)) begin
        w_a_word = r_a[16*i +: 16];
        w_b_word = r_b[16*i +: 16];
      end
    end
  end

  cla_16_bit u_cla (
    .A    (w_a_word),
    .B    (w_b_word),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_cout),
    .P    (w_cla_p_unused),
    .G    (w_cla_g_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (r_k == KW'(i)) r_sum[16*i +: 16] <= w_s;
          end
          r_carry <= w_cout;
          r_k     <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            // Top word's S[15] is the sign bit of the full-width sum.
            r_cout      <= w_cout;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_s[15] != r_a[W-1]);
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Testbench for multiword_adder_seq (WORDS=4): directed vectors with
// hand-computed results, backpressure, mid-operation reset, and a
// randomized run against a behavioural wide add.

module tb_multiword_adder_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  multiword_adder_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers an operand pair and returns just after the acceptance edge,
  // scrambling the inputs so any late sampling shows up in the result.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    cin = ~cv;
    chk("busy_in_ready", in_ready, 0);
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec,
                             input logic eo);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_lat"}, n, WORDS);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_rdy_lo"}, in_ready, 0);
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_lo"}, out_valid, 0);
    chk({tag, "_rdy_hi"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] av, bv, hold_sum;
    logic         cv, eo;
    logic [W:0]   full;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();

    // Carry crosses from word 0 into word 1.
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_result("t1", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    release_op("t1");

    // Carry-in ripples through every word and out the top.
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_result("t2", 64'h0, 1'b1, 1'b0);
    release_op("t2");

    // Largest positive plus one.
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_result("t3", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    release_op("t3");

    // Two negatives overflowing to positive, with carry-out.
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    wait_result("t3b", 64'h0000_0000_0000_0001, 1'b1, 1'b1);
    release_op("t3b");

    // Backpressure with a competing request pending.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    wait_result("t4", 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 64'd100;
    b = 64'd200;
    cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_sum", sum, 64'h2345_6789_ABCD_F001);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_rdy", in_ready, 0);
    end
    release_op("t4");
    start_op(64'd100, 64'd200, 1'b0);
    wait_result("t4n", 64'd300, 1'b0, 1'b0);
    release_op("t4n");

    // Reset two cycles into RUN aborts the operation.
    start_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_rdy", in_ready, 1);
    chk("t5_sum", sum, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_stale", out_valid, 0);
    end
    start_op(64'd5, 64'd7, 1'b0);
    wait_result("t5n", 64'd12, 1'b0, 1'b0);
    release_op("t5n");

    // Random operands and handshake gaps against a behavioural wide add.
    for (int t = 0; t < 1000; t++) begin
      av = {$urandom(), $urandom()};
      bv = {$urandom(), $urandom()};
      cv = 1'($urandom_range(0, 1));
      full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      eo = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      start_op(av, bv, cv);
      wait_result("rnd", full[W-1:0], full[W], eo);
      hold_sum = sum;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tick();
        chk("rnd_hold", sum, hold_sum);
      end
      release_op("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
